// File: rtl/arbiter4_rr_if.sv
// arbiter4_rr_if: request/grant bundle between four requesters and the
// round-robin arbiter. The requester side (master) drives req/done; the
// arbiter side (slave) drives the one-hot grant, encoded index, valid and
// timeout pulse.
interface arbiter4_rr_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       o1;
  logic       o2;
  logic       v;
  logic       tout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  o1,
    input  o2,
    input  v,
    input  tout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output o1,
    output o2,
    output v,
    output tout
  );
endinterface

// File: rtl/arbiter4_rr.sv
// arbiter4_rr: four-requester round-robin arbiter with grant hold.
// A holder keeps the grant until it pulses done or drops its request; on
// release the arbiter re-arbitrates at the same edge with the old holder
// masked, so handovers have no idle cycle. Priority pointer moves to the
// winner+1 after every grant. All outputs decode from registered state.
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forces
// a release after MAX_HOLD consecutive grant cycles and pulses tout.
module arbiter4_rr #(
  parameter logic [7:0] MAX_HOLD = 8'd15
) (
  input  logic           clk,
  input  logic           rst_n,
  arbiter4_rr_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] h_reg, h_next;

  logic       rel_normal;
  logic       timeout_hit;
  logic       rel;
  logic [3:0] arb_req;
  logic       win_found;
  logic [1:0] win_idx;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_reg, cnt_next;
  logic       tout_reg;

  // Forced release once the holder has used up its allowance without
  // releasing on its own; a voluntary release in the same cycle wins.
  always_comb begin
    timeout_hit = 1'b0;
    if (state_reg == GRANT && !rel_normal && cnt_reg == (MAX_HOLD - 8'd1))
      timeout_hit = 1'b1;
  end

  // Hold counter: cleared by each new grant, counts held cycles otherwise.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE && win_found)
      cnt_next = 8'd0;
    else if (state_reg == GRANT && rel && win_found)
      cnt_next = 8'd0;
    else if (state_reg == GRANT && !rel)
      cnt_next = cnt_reg + 8'd1;
    else if (state_next == IDLE)
      cnt_next = 8'd0;
  end

  // Counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 8'd0;
      tout_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tout_reg <= timeout_hit;
    end
  end

  assign bus.tout = tout_reg;
`else
  // Without the timeout feature the parameter has no effect.
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign timeout_hit     = 1'b0;
  assign bus.tout        = 1'b0;
`endif

  // Release detection and request masking: the outgoing holder is excluded
  // from the decision made at its own release edge.
  always_comb begin
    rel_normal = 1'b0;
    arb_req    = bus.req;
    if (state_reg == GRANT) begin
      rel_normal      = bus.done | ~bus.req[h_reg];
      arb_req[h_reg]  = 1'b0;
    end
  end

  assign rel = rel_normal | timeout_hit;

  // Round-robin search: first asserted request scanning ptr, ptr+1, ...
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_reg + 2'(i);
      if (!win_found && arb_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state logic: grant from IDLE, or hand over / go idle on release.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    h_next     = h_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          h_next     = win_idx;
          ptr_next   = win_idx + 2'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          if (win_found) begin
            h_next   = win_idx;
            ptr_next = win_idx + 2'd1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and holder registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      h_reg     <= 2'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      h_reg     <= h_next;
    end
  end

  // Output decode from registered state only.
  assign bus.v  = (state_reg == GRANT);
  assign bus.o1 = bus.v & h_reg[1];
  assign bus.o2 = bus.v & h_reg[0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
      assign bus.gnt[gi] = bus.v & (h_reg == 2'(gi));
    end
  endgenerate

endmodule

// File: doc/arbiter4_rr.md
# arbiter4_rr

- Four-requester round-robin arbiter with grant hold, for sharing one resource among four request lines.
- Output is both a one-hot grant vector and a 2-bit encoded grant index with a valid flag, in the same o1/o2/v convention as the team's 4-to-2 encoder.
- Sits in front of any shared datapath unit. Once a requester is granted, it keeps the grant until it releases it.
- Priority rotates after every grant, so no requester can be starved.

## Interface
Parameters:
- MAX_HOLD, 8'd15, maximum consecutive grant cycles before forced release (1..255); used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  4  request lines; req[k] high = requester k wants the resource
- done  input  1  single-cycle release strobe from the current holder
- gnt  output  4  one-hot grant, registered; all zero when idle
- o1  output  1  encoded grant index MSB (holder k: o1 = k[1])
- o2  output  1  encoded grant index LSB (holder k: o2 = k[0])
- v  output  1  grant valid; equals |gnt
- tout  output  1  one-cycle pulse when a grant is revoked by timeout; tied 0 when ARB_TIMEOUT_EN is undefined

## Operation
- State machine has two states:
  - IDLE: no grant.
  - GRANT: one holder, index h.
- Internal state:
  - Priority pointer ptr[1:0].
  - Holder index h[1:0].
  - hold counter cnt[7:0], present only with ARB_TIMEOUT_EN.
- Arbitration: among the asserted req bits, pick the first one scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req != 0, go to GRANT with h = the winner, and set ptr = winner+1 (mod 4).
  - Else stay in IDLE.
- GRANT, release condition = done | ~req[h] (| timeout):
  - On release, arbitrate again in the same edge, with req[h] masked for that one decision.
  - If another request wins, switch straight to it: zero bubble, and ptr is updated again.
  - Otherwise go to IDLE.
  - If there is no release, hold h; gnt stays stable.
- done is ignored while in IDLE.
- Simultaneous done and new requests: the release and the new grant both take effect at the same edge.
- Outputs are decoded from registered state only, so there is no combinational path from req or done to gnt.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, ptr = 0, h = 0, cnt = 0
  - gnt = 4'b0000, o1 = 0, o2 = 0, v = 0, tout = 0
- Reset asserted mid-grant drops the grant immediately, with no wait for a clock edge.
- Request to grant latency: req sampled at edge N gives gnt valid after edge N (1 cycle).
- done sampled at edge N: gnt drops, or moves to the next requester, after edge N.
- Handover between two requesters has no idle cycle.
- After release, the holder can be re-granted only on a later arbitration, and only if no other requester is ahead of it in rotation.
- Wrap-around: ptr after a grant to requester 3 is 0.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - cnt clears on each new grant and increments on each GRANT cycle without a release.
  - When cnt == MAX_HOLD-1 and there is still no release, a forced release happens at the next edge, with the same re-arbitration and masking as done.
  - tout is high for exactly the cycle after that edge.
  - A release in the same cycle as the timeout counts as a normal release, with no tout.
- Undefined: no counter, tout = 0 constantly, and a grant is held indefinitely.

## Test plan
- Reset:
  - Stimulus: rst_n = 0 with req = 4'b1111 and clocks running.
  - Required: gnt = 0, v = 0, o1o2 = 00, tout = 0 throughout.
  - After release: gnt = 4'b0001 one cycle later, o1o2 = 00, v = 1.
- Rotation:
  - Stimulus: req = 4'b1111, done pulsed every 3rd cycle.
  - Required: grant sequence 0,1,2,3,0; o1o2 = 00,01,10,11,00; no v gap at handovers.
- Drop release:
  - Stimulus: requester 2 alone granted, then req[2] = 0 with no done.
  - Required: gnt = 0, v = 0 next cycle.
  - Then req = 4'b1001: grant goes to 3, since ptr = 3.
- Simultaneous events:
  - Stimulus: holder 1 pulses done in the same cycle req[0] and req[3] rise.
  - Required: next gnt = 4'b0100 if req[2] is set, else 4'b1000.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4):
  - Stimulus: holder 0 never releases while req[1] = 1.
  - Required: gnt = 4'b0001 for exactly 4 cycles, then gnt = 4'b0010 with tout = 1 for one cycle.
  - Without the macro: gnt = 4'b0001 held 20+ cycles, tout = 0.
- Asynchronous reset mid-grant:
  - Stimulus: assert rst_n low between edges while gnt = 4'b0100.
  - Required: gnt = 0 before the next edge; after release the first grant again starts at ptr = 0.
